// File: rtl/wb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : wb_pkg
// Description : Shared constants, source encoding and helpers for the
//               writeback port arbiter and its request queues.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int XLEN          = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int WB_FIFO_DEPTH = 2;
    // Queue entry layout: {RdSel, RdDat}, destination in the MSBs.
    localparam int ENTRY_W       = REG_ADDR_W + XLEN;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    // One-hot decode of a register index into a full-width pending mask.
    function automatic logic [XLEN-1:0] sel_onehot(input logic [REG_ADDR_W-1:0] sel);
        logic [XLEN-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular-buffer request queue with registered head (no
//               push-to-pop bypass). Exposes a per-slot valid vector and the
//               tag field (MSBs) of every slot so the owner can build a
//               pending-destination mask.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push/i_data   - write request (ignored when full)
//               i_pop           - remove head (ignored when empty)
//               o_head          - current head entry
//               o_full/o_empty  - occupancy flags
//               o_vld/o_tags    - per-slot valid bit and tag field
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37,
    parameter int TAG_W = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [DEPTH-1:0]            o_vld,
    output logic [DEPTH-1:0][TAG_W-1:0] o_tags
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [AW-1:0]               r_rd_ptr;
    logic [AW-1:0]               r_wr_ptr;
    logic [AW:0]                 r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [AW-1:0] w_off;
        o_vld  = '0;
        o_tags = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off     = AW'(i) - r_rd_ptr;
            o_vld[i]  = ({1'b0, w_off} < r_count);
            o_tags[i] = r_mem[i][WIDTH-1 -: TAG_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Merges ALU and load-unit writeback requests onto a single
//               register-file write port. Each source is buffered in its own
//               queue; heads are arbitrated round-robin and the winner is
//               registered onto the port. Writes to x0 are arbitrated but
//               never enable the register file.
// Ports       : Clk, Rst                      - clock, sync active-high reset
//               AluVld/AluRdSel/AluRdDat/AluRdy - ALU request handshake
//               MemVld/MemRdSel/MemRdDat/MemRdy - load request handshake
//               Wen/RDSel/RDDat               - register-file write port
//               PendMask                      - destinations queued or on port
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  AluVld,
    input  logic [REG_ADDR_W-1:0] AluRdSel,
    input  logic [XLEN-1:0]       AluRdDat,
    output logic                  AluRdy,
    input  logic                  MemVld,
    input  logic [REG_ADDR_W-1:0] MemRdSel,
    input  logic [XLEN-1:0]       MemRdDat,
    output logic                  MemRdy,
    output logic                  Wen,
    output logic [REG_ADDR_W-1:0] RDSel,
    output logic [XLEN-1:0]       RDDat,
    output logic [XLEN-1:0]       PendMask
);

    logic                                  w_alu_full, w_alu_empty;
    logic                                  w_mem_full, w_mem_empty;
    logic [ENTRY_W-1:0]                    w_alu_head, w_mem_head;
    logic [FIFO_DEPTH-1:0]                 w_alu_vld, w_mem_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_alu_tags, w_mem_tags;
    logic                                  w_alu_push, w_mem_push;
    logic                                  w_alu_pop, w_mem_pop;

    logic                                  w_grant_vld;
    wb_src_e                               w_grant_src;
    logic [ENTRY_W-1:0]                    w_grant_entry;
    wb_src_e                               w_last_nxt;
    logic [XLEN-1:0]                       w_pend;

    wb_src_e                               r_last;
    logic                                  r_wen;
    logic [REG_ADDR_W-1:0]                 r_rdsel;
    logic [XLEN-1:0]                       r_rddat;

    // Ready depends on occupancy only: a same-cycle pop never frees a slot.
    assign AluRdy     = ~w_alu_full & ~Rst;
    assign MemRdy     = ~w_mem_full & ~Rst;
    assign w_alu_push = AluVld & AluRdy;
    assign w_mem_push = MemVld & MemRdy;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .TAG_W (REG_ADDR_W)
    ) u_alu_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .i_push  (w_alu_push),
        .i_data  ({AluRdSel, AluRdDat}),
        .i_pop   (w_alu_pop),
        .o_head  (w_alu_head),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty),
        .o_vld   (w_alu_vld),
        .o_tags  (w_alu_tags)
    );

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W),
        .TAG_W (REG_ADDR_W)
    ) u_mem_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .i_push  (w_mem_push),
        .i_data  ({MemRdSel, MemRdDat}),
        .i_pop   (w_mem_pop),
        .o_head  (w_mem_head),
        .o_full  (w_mem_full),
        .o_empty (w_mem_empty),
        .o_vld   (w_mem_vld),
        .o_tags  (w_mem_tags)
    );

    // Round-robin: under contention the source that did not win last time
    // is granted; r_last only moves on an actual grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_src = SRC_ALU;
        w_last_nxt  = r_last;
        if (!w_alu_empty && !w_mem_empty) begin
            w_grant_vld = 1'b1;
            w_grant_src = (r_last == SRC_ALU) ? SRC_MEM : SRC_ALU;
        end else if (!w_alu_empty) begin
            w_grant_vld = 1'b1;
            w_grant_src = SRC_ALU;
        end else if (!w_mem_empty) begin
            w_grant_vld = 1'b1;
            w_grant_src = SRC_MEM;
        end
        if (w_grant_vld) begin
            w_last_nxt = w_grant_src;
        end
    end

    assign w_alu_pop     = w_grant_vld & (w_grant_src == SRC_ALU);
    assign w_mem_pop     = w_grant_vld & (w_grant_src == SRC_MEM);
    assign w_grant_entry = (w_grant_src == SRC_MEM) ? w_mem_head : w_alu_head;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_last  <= SRC_MEM;
            r_wen   <= 1'b0;
            r_rdsel <= '0;
            r_rddat <= '0;
        end else begin
            r_last <= w_last_nxt;
            // x0 writes still occupy the port but never enable the write.
            r_wen  <= w_grant_vld &&
                      (w_grant_entry[ENTRY_W-1 -: REG_ADDR_W] != '0);
            if (w_grant_vld) begin
                r_rdsel <= w_grant_entry[ENTRY_W-1 -: REG_ADDR_W];
                r_rddat <= w_grant_entry[XLEN-1:0];
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_alu_vld[i]) begin
                w_pend = w_pend | sel_onehot(w_alu_tags[i]);
            end
            if (w_mem_vld[i]) begin
                w_pend = w_pend | sel_onehot(w_mem_tags[i]);
            end
        end
        if (r_wen) begin
            w_pend = w_pend | sel_onehot(r_rdsel);
        end
        w_pend[0] = 1'b0;
    end

    assign Wen      = r_wen;
    assign RDSel    = r_rdsel;
    assign RDDat    = r_rddat;
    assign PendMask = w_pend;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed scoreboard bench for wb_port_arbiter. Expected port
//               writes are queued when stimulus is issued; a monitor pops and
//               compares on every enabled write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        AluVld = 1'b0;
    logic [4:0]  AluRdSel = '0;
    logic [31:0] AluRdDat = '0;
    logic        AluRdy;
    logic        MemVld = 1'b0;
    logic [4:0]  MemRdSel = '0;
    logic [31:0] MemRdDat = '0;
    logic        MemRdy;
    logic        Wen;
    logic [4:0]  RDSel;
    logic [31:0] RDDat;
    logic [31:0] PendMask;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [36:0] exp_q[$];
    int win_first = -1;
    int win_last  = -1;
    int win_cnt   = 0;
    int a_st, m_st;

    wb_port_arbiter #(.FIFO_DEPTH(2)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .AluVld   (AluVld),
        .AluRdSel (AluRdSel),
        .AluRdDat (AluRdDat),
        .AluRdy   (AluRdy),
        .MemVld   (MemVld),
        .MemRdSel (MemRdSel),
        .MemRdDat (MemRdDat),
        .MemRdy   (MemRdy),
        .Wen      (Wen),
        .RDSel    (RDSel),
        .RDDat    (RDDat),
        .PendMask (PendMask)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every enabled write outside reset must match the queue head.
    always @(negedge Clk) begin
        logic [36:0] e;
        if (!Rst && Wen === 1'b1) begin
            if (win_first < 0) win_first = cyc;
            win_last = cyc;
            win_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wen: got sel %0d dat %h, required no write", RDSel, RDDat);
            end else begin
                e = exp_q.pop_front();
                chk("port_sel", {27'b0, RDSel}, {27'b0, e[36:32]});
                chk("port_dat", RDDat, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] sel, input logic [31:0] dat);
        exp_q.push_back({sel, dat});
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    // Holds each request valid until accepted; reports how many accepts
    // happened before the first not-ready cycle (-1 if never stalled).
    task automatic drive(input bit is_mem, input int n, input int base_sel,
                         input logic [31:0] base_dat, output int acc_before_stall);
        int  acc;
        bit  stalled;
        bit  rdy;
        bit  done;
        acc = 0;
        stalled = 1'b0;
        acc_before_stall = -1;
        for (int k = 0; k < n; k++) begin
            if (is_mem) begin
                MemVld = 1'b1; MemRdSel = 5'(base_sel + k); MemRdDat = base_dat + 32'(k);
            end else begin
                AluVld = 1'b1; AluRdSel = 5'(base_sel + k); AluRdDat = base_dat + 32'(k);
            end
            done = 1'b0;
            for (int t = 0; t < 50 && !done; t++) begin
                @(negedge Clk);
                rdy = is_mem ? MemRdy : AluRdy;
                @(posedge Clk);
                #1;
                if (rdy) begin
                    done = 1'b1;
                end else if (!stalled) begin
                    stalled = 1'b1;
                    acc_before_stall = acc;
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept for src %0d item %0d, required accept", is_mem, k);
            end
            acc++;
        end
        if (is_mem) MemVld = 1'b0; else AluVld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        @(negedge Clk);
        chk("rst_alurdy", {31'b0, AluRdy}, 32'd0);
        chk("rst_memrdy", {31'b0, MemRdy}, 32'd0);
        step();
        Rst = 1'b0;
        @(negedge Clk);
        chk("init_wen", {31'b0, Wen}, 32'd0);
        chk("init_rdsel", {27'b0, RDSel}, 32'd0);
        chk("init_rddat", RDDat, 32'd0);
        chk("init_pend", PendMask, 32'd0);
        chk("init_alurdy", {31'b0, AluRdy}, 32'd1);
        step();

        // Single ALU write: Wen two cycles after accept, PendMask[5] throughout
        AluVld = 1'b1; AluRdSel = 5'd5; AluRdDat = 32'hDEADBEEF;
        push_exp(5'd5, 32'hDEADBEEF);
        @(negedge Clk);
        chk("t1_rdy", {31'b0, AluRdy}, 32'd1);
        step();
        AluVld = 1'b0;
        @(negedge Clk);
        chk("t1_wen_c1", {31'b0, Wen}, 32'd0);
        chk("t1_pend_c1", PendMask, 32'h0000_0020);
        step();
        @(negedge Clk);
        chk("t1_wen_c2", {31'b0, Wen}, 32'd1);
        chk("t1_pend_c2", PendMask, 32'h0000_0020);
        step();
        @(negedge Clk);
        chk("t1_wen_c3", {31'b0, Wen}, 32'd0);
        chk("t1_pend_c3", PendMask, 32'd0);
        chk("t1_hold_sel", {27'b0, RDSel}, 32'd5);
        wait_drain("t1_drain");

        // Saturated sources alternate ALU, MEM with no idle port cycles
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push_exp(5'(1 + k), 32'hA000_0001 + 32'(k));
            push_exp(5'(11 + k), 32'hB000_0011 + 32'(k));
        end
        win_first = -1; win_last = -1; win_cnt = 0;
        fork
            drive(1'b0, 4, 1, 32'hA000_0001, a_st);
            drive(1'b1, 4, 11, 32'hB000_0011, m_st);
        join
        wait_drain("t2_drain");
        chk("t2_wen_count", win_cnt, 32'd8);
        chk("t2_no_idle_span", win_last - win_first + 1, 32'd8);

        // MEM backpressure while ALU holds the port: 2 accepts then stall
        do_reset();
        push_exp(5'd6,  32'hC000_0006);
        push_exp(5'd21, 32'hD000_0021);
        push_exp(5'd7,  32'hC000_0007);
        push_exp(5'd22, 32'hD000_0022);
        push_exp(5'd23, 32'hD000_0023);
        fork
            drive(1'b0, 2, 6, 32'hC000_0006, a_st);
            drive(1'b1, 3, 21, 32'hD000_0021, m_st);
        join
        chk("t3_mem_accepts_before_stall", m_st, 32'd2);
        chk("t3_alu_never_stalled", a_st, 32'hFFFF_FFFF);
        wait_drain("t3_drain");

        // x0 write: arbitrated, port updated, never enabled, never pending
        AluVld = 1'b1; AluRdSel = 5'd0; AluRdDat = 32'h12345678;
        @(negedge Clk);
        chk("t4_pend_c0", PendMask, 32'd0);
        step();
        AluVld = 1'b0;
        @(negedge Clk);
        chk("t4_wen_c1", {31'b0, Wen}, 32'd0);
        chk("t4_pend_c1", PendMask, 32'd0);
        step();
        @(negedge Clk);
        chk("t4_wen_out", {31'b0, Wen}, 32'd0);
        chk("t4_rdsel_out", {27'b0, RDSel}, 32'd0);
        chk("t4_rddat_out", RDDat, 32'h12345678);
        chk("t4_pend_out", PendMask, 32'd0);
        step();

        // Mid-operation reset with three entries queued
        AluVld = 1'b1; AluRdSel = 5'd8;  AluRdDat = 32'hE000_0008;
        MemVld = 1'b1; MemRdSel = 5'd18; MemRdDat = 32'hF000_0018;
        step();
        AluRdSel = 5'd10; AluRdDat = 32'hE000_0010;
        MemRdSel = 5'd20; MemRdDat = 32'hF000_0020;
        step();
        AluVld = 1'b0; MemVld = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        chk("t5_pend_before_rst", PendMask, 32'h0014_0500);
        chk("t5_alurdy_in_rst", {31'b0, AluRdy}, 32'd0);
        chk("t5_memrdy_in_rst", {31'b0, MemRdy}, 32'd0);
        step();
        Rst = 1'b0;
        AluVld = 1'b1; AluRdSel = 5'd9;  AluRdDat = 32'hE000_0009;
        MemVld = 1'b1; MemRdSel = 5'd19; MemRdDat = 32'hF000_0019;
        push_exp(5'd9,  32'hE000_0009);
        push_exp(5'd19, 32'hF000_0019);
        @(negedge Clk);
        chk("t5_wen_after_rst", {31'b0, Wen}, 32'd0);
        chk("t5_alurdy_after", {31'b0, AluRdy}, 32'd1);
        chk("t5_memrdy_after", {31'b0, MemRdy}, 32'd1);
        chk("t5_pend_after", PendMask, 32'd0);
        chk("t5_rdsel_after", {27'b0, RDSel}, 32'd0);
        chk("t5_rddat_after", RDDat, 32'd0);
        step();
        AluVld = 1'b0; MemVld = 1'b0;
        wait_drain("t5_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 2, entries per requester queue (power of two, 2..8).
REQ-002 SHALL have port: Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 SHALL have port: Rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: AluVld  input  1  ALU writeback request valid.
REQ-005 SHALL have port: AluRdSel  input  5  ALU destination register.
REQ-006 SHALL have port: AluRdDat  input  32  ALU result.
REQ-007 SHALL have port: AluRdy  output  1  ALU queue can accept.
REQ-008 SHALL have port: MemVld  input  1  load-unit writeback request valid.
REQ-009 SHALL have port: MemRdSel  input  5  load destination register.
REQ-010 SHALL have port: MemRdDat  input  32  load data.
REQ-011 SHALL have port: MemRdy  output  1  load queue can accept.
REQ-012 SHALL have port: Wen  output  1  register-file write enable.
REQ-013 SHALL have port: RDSel  output  5  register-file write address.
REQ-014 SHALL have port: RDDat  output  32  register-file write data.
REQ-015 SHALL have port: PendMask  output  32  bit i set while a write to register i is queued or on the port.

Function
REQ-016 SHALL accept a request on posedge Clk when Vld and Rdy are both 1; Rdy SHALL be 1 exactly when that queue holds fewer than FIFO_DEPTH entries and Rst is 0.
REQ-017 SHALL NOT accept a push into a full queue even when a pop occurs in the same cycle (Rdy depends on occupancy only).
REQ-018 SHALL preserve order within each source; no ordering guarantee across sources.
REQ-019 SHALL arbitrate the two queue heads each cycle with one-bit state LAST (values ALU, MEM): both non-empty -> grant the source not equal to LAST; one non-empty -> grant it; none -> no grant.
REQ-020 SHALL update LAST to the granted source on every grant, and hold it otherwise.
REQ-021 SHALL pop the granted head and register it onto Wen/RDSel/RDDat on the same posedge: latency 1 cycle from head-of-queue to port, 2 cycles from accept to Wen when the port is idle.
REQ-022 SHALL sustain one write per cycle; with both sources saturated grants SHALL alternate ALU, MEM, ALU, ...
REQ-023 SHALL accept requests with RdSel = 0, arbitrate them normally, but drive Wen = 0 in their output cycle (RDSel/RDDat still updated).
REQ-024 SHALL drive Wen = 0 in any cycle with no grant in the previous cycle; RDSel/RDDat hold their last values.
REQ-025 SHALL compute PendMask combinationally as OR over all valid queue entries and the output register (when Wen = 1) of one-hot(RdSel); bit 0 SHALL always be 0.
REQ-026 SHALL accept a push into an empty queue and allow grant of that entry no earlier than the next cycle (no bypass).

Reset
REQ-027 SHALL, on posedge Clk with Rst = 1, empty both queues, set LAST = MEM (ALU wins first contention), Wen = 0, RDSel = 0, RDDat = 0.
REQ-028 SHALL drive AluRdy = MemRdy = 0 while Rst = 1 and PendMask = 0 from the first cycle after reset.
REQ-029 SHALL discard queued and in-flight writes when Rst asserts mid-operation; no Wen pulse SHALL occur in the cycle after a reset cycle.

Structure
REQ-030 SHALL place XLEN = 32, REG_ADDR_W = 5, default FIFO_DEPTH and source encoding (ALU = 0, MEM = 1) in shared package wb_pkg.
REQ-031 SHALL implement each queue as one instance of sub-module wb_fifo (parameterised depth, data = {RdSel, RdDat}, push/pop/full/empty, entry-valid vector for PendMask), instantiated twice.

Verification
REQ-032 SHALL cover: single ALU push (x5, 0xDEADBEEF), idle otherwise -> Wen = 1, RDSel = 5, RDDat = 0xDEADBEEF exactly 2 cycles after accept; PendMask[5] = 1 from accept through the Wen cycle.
REQ-033 SHALL cover: both sources push 4 requests every cycle (ALU x1..x4, MEM x11..x14) -> port sequence x1, x11, x2, x12, x3, x13, x4, x14, no idle cycles once started.
REQ-034 SHALL cover: MEM held valid with no pops possible beyond capacity (FIFO_DEPTH = 2, port busy with ALU) -> MemRdy drops to 0 after 2 accepts, no data lost or duplicated.
REQ-035 SHALL cover: ALU push to x0 with 0x12345678 -> output cycle shows Wen = 0, PendMask = 0 throughout.
REQ-036 SHALL cover: Rst asserted for one cycle with 3 entries queued -> Wen = 0 following cycle, Rdy = 1 and PendMask = 0 after reset, next grant goes to ALU under contention.
